m68k_bus_responder: RTL and testbench
=====================================

# m68k_bus_responder

Synchronous word-wide RAM that answers V68k bus cycles from the memory side of the bus. It decodes A/AS/UDS/LDS/RW against an address window and applies programmable wait states. For reads it drives D and DTACK; for writes it updates the selected byte lanes. It is the first memory target for instruction fetch and data access in simulation and FPGA bring-up.

## Interface
Parameters:
- BASE_ADDR, 24'h000000 — byte base address of the window; must be aligned to 2^(DEPTH_LOG2+1).
- DEPTH_LOG2, 10 — log2 of the word count (default 1024 words = 2 KB).
- WAIT_STATES, 1 — extra cycles inserted before the access is performed; legal range 0–15.
- INIT_FILE, "" — hex image loaded with $readmemh at elaboration when non-empty.

Ports (one clock; reset is synchronous and active-high):
- CLK  input  1  — system clock; all logic acts on the rising edge.
- RESET  input  1  — synchronous, active-high.
- A  input  23  — word address A[23:1].
- AS  input  1  — address strobe, active-low.
- UDS  input  1  — upper data strobe (D[15:8]), active-low.
- LDS  input  1  — lower data strobe (D[7:0]), active-low.
- RW  input  1  — 1 = read, 0 = write.
- D  inout  16  — data bus; driven only in ACK during a read, high-Z otherwise.
- DTACK  output  1  — data acknowledge, active-high, registered.

## Operation
- Hit: AS==0 and A[23:DEPTH_LOG2+1] == BASE_ADDR[23:DEPTH_LOG2+1]. Word offset = A[DEPTH_LOG2:1]. A miss produces no response: DTACK stays 0 and D is not driven.
- States:
  - IDLE: on a hit, latch the offset and RW, load cnt = WAIT_STATES, go to WAIT.
  - WAIT:
    - AS==1 (aborted cycle): go to IDLE; no write is performed and no DTACK is issued.
    - cnt != 0: decrement cnt.
    - cnt == 0: perform the access.
      - Read: rdata <= mem[offset].
      - Write: sample UDS, LDS and D on this same edge; write D[15:8] if UDS==0 and D[7:0] if LDS==0.
      - Go to ACK and set DTACK to 1.
  - ACK: hold DTACK=1. During a read, drive D = rdata. When AS is sampled 1, clear DTACK, release D and go to IDLE.
- Both strobes high during a write: the cycle is acknowledged and memory is unchanged. A read always returns the full word regardless of the strobes.
- Memory contents are not cleared by RESET.

## Timing
- Reset values: state = IDLE, DTACK = 0, D = high-Z, cnt = 0.
- Reset in WAIT before the perform edge: the write is dropped. Reset in ACK: DTACK falls on the reset edge.
- Latency: if a hit is first sampled at edge k, the access is performed and DTACK rises at edge k+1+WAIT_STATES.
  - Read data is valid on D from that same edge.
  - Default WAIT_STATES=1 gives DTACK at k+2.
- Release: when AS is sampled 1 at edge m in ACK, DTACK = 0 and D = Z after edge m.
- Back-to-back cycles: a hit sampled at edge m+1 (IDLE) starts a new cycle. A new cycle is never accepted while in ACK.
- AS held low across cycles without a high sample: stay in ACK and do not re-access. One access is performed per AS assertion.
- Simultaneous RESET and hit: RESET wins, state = IDLE.
- Strobes are ignored outside the perform edge.

## Test plan
- Read, WAIT_STATES=1, INIT word[0]=16'h4E71: AS=0, A=0, RW=1 sampled at edge k -> DTACK=1 and D=16'h4E71 after edge k+2. AS=1 at edge m -> DTACK=0 and D=Z after m.
- Byte-lane write to byte address 0x000010 (word 8), which initially holds 16'h1234: write 16'hABCD with UDS=0, LDS=1 -> readback 16'hAB34. Then write 16'h5678 with UDS=1, LDS=0 -> 16'hAB78.
- Window miss, BASE_ADDR=24'h000000, DEPTH_LOG2=10: read A=12'h800 (byte 0x001000) -> DTACK stays 0 and D stays Z for 20 cycles.
- Abort: WAIT_STATES=3, write 16'hFFFF to word 4, AS raised 2 edges after the hit -> no DTACK; word 4 unchanged.
- Reset mid-ACK during a read: RESET=1 for one edge -> DTACK=0 and D=Z immediately; the next hit completes normally.
- WAIT_STATES=0, two back-to-back reads of words 1 and 2 with AS high for exactly one edge between them -> each DTACK at k+1 with the correct data.

Source files
------------

// File: rtl/m68k_bus_responder.sv
// Word-wide RAM target for V68k bus cycles: decodes an address window, inserts
// WAIT_STATES cycles, then reads or byte-lane-writes memory and holds DTACK until AS rises.
module m68k_bus_responder #(
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_STATES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [23:1] A,
    input  logic        AS,
    input  logic        UDS,
    input  logic        LDS,
    input  logic        RW,
    inout  wire  [15:0] D,
    output logic        DTACK
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] off_q, off_d;
    logic                  rw_q, rw_d;
    logic                  dtack_q, dtack_d;
    logic                  rd_en, wr_en;
    logic                  hit;
    logic [15:0]           rdata_q;
    logic [15:0]           mem [DEPTH];

    assign hit = !AS && (A[23:DEPTH_LOG2+1] == BASE_ADDR[23:DEPTH_LOG2+1]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        rw_d    = rw_q;
        dtack_d = dtack_q;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    off_d   = A[DEPTH_LOG2:1];
                    rw_d    = RW;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // An abort takes priority even on the edge that would perform the access.
                if (AS) begin
                    state_d = S_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rd_en   = rw_q;
                    wr_en   = !rw_q && !RESET;
                    dtack_d = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (AS) begin
                    dtack_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            off_q   <= '0;
            rw_q    <= 1'b1;
            dtack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            rw_q    <= rw_d;
            dtack_q <= dtack_d;
        end
    end

    // Memory survives RESET; strobes and write data only matter on the perform edge.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            if (!UDS) mem[off_q][15:8] <= D[15:8];
            if (!LDS) mem[off_q][7:0]  <= D[7:0];
        end
        if (rd_en) rdata_q <= mem[off_q];
    end

    assign D     = (state_q == S_ACK && rw_q) ? rdata_q : {16{1'bz}};
    assign DTACK = dtack_q;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Bench for m68k_bus_responder: three instances (1, 3 and 0 wait states) driven by a bus-master
// model; the master parks D at 16'h0000 whenever the responder is expected to be off the bus.
module tb_m68k_bus_responder;

    localparam int          NDUT = 3;
    localparam logic [15:0] PARK = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:1] addr   [NDUT];
    logic        as_n   [NDUT];
    logic        uds_n  [NDUT];
    logic        lds_n  [NDUT];
    logic        rw     [NDUT];
    logic        tb_den [NDUT];
    logic [15:0] tb_dout[NDUT];
    wire  [15:0] d_obs  [NDUT];
    wire         dtack_w[NDUT];

    int          ws_tab [NDUT] = '{1, 3, 0};
    logic [15:0] model  [NDUT][32];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        wire [15:0] d_bus;
        assign d_bus    = tb_den[g] ? tb_dout[g] : 16'hzzzz;
        assign d_obs[g] = d_bus;
        m68k_bus_responder #(
            .BASE_ADDR  (24'h000000),
            .DEPTH_LOG2 (10),
            .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 3 : 0)),
            .INIT_FILE  ("")
        ) dut (
            .CLK  (clk),
            .RESET(rst),
            .A    (addr[g]),
            .AS   (as_n[g]),
            .UDS  (uds_n[g]),
            .LDS  (lds_n[g]),
            .RW   (rw[g]),
            .D    (d_bus),
            .DTACK(dtack_w[g])
        );
    end

    task automatic start_cycle(input int g, input bit rd, input logic [23:1] a,
                               input logic u, input logic l, input logic [15:0] wd);
        addr[g]  = a;
        rw[g]    = rd;
        uds_n[g] = u;
        lds_n[g] = l;
        as_n[g]  = 1'b0;
        tb_den[g]  = !rd;
        tb_dout[g] = rd ? PARK : wd;
    endtask

    // lat = edges between the edge that samples the hit and the edge that raises DTACK
    task automatic wait_ack(input int g, input int limit, output bit acked, output int lat,
                            output logic [15:0] data);
        acked = 1'b0;
        lat   = -1;
        data  = 16'hxxxx;
        for (int n = 1; n <= limit && !acked; n++) begin
            @(posedge clk); #1;
            if (dtack_w[g] === 1'b1) begin
                acked = 1'b1;
                lat   = n - 1;
                data  = d_obs[g];
            end
        end
    endtask

    task automatic end_cycle(input int g, output logic dt, output logic [15:0] dv);
        as_n[g]  = 1'b1;
        uds_n[g] = 1'b1;
        lds_n[g] = 1'b1;
        @(posedge clk); #1;
        dt = dtack_w[g];
        tb_den[g]  = 1'b1;
        tb_dout[g] = PARK;
        #1;
        dv = d_obs[g];
    endtask

    task automatic do_cycle(input int g, input bit rd, input logic [23:1] a, input logic u,
                            input logic l, input logic [15:0] wd, output bit acked,
                            output int lat, output logic [15:0] data, output logic dt_after,
                            output logic [15:0] d_after);
        start_cycle(g, rd, a, u, l, wd);
        wait_ack(g, 40, acked, lat, data);
        end_cycle(g, dt_after, d_after);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NDUT; g++) begin
            checks++;
            if (dtack_w[g] !== 1'b0) begin
                errors++; $display("FAIL reset_dtack g=%0d got=%b exp=0", g, dtack_w[g]);
            end
            checks++;
            if (d_obs[g] !== PARK) begin
                errors++; $display("FAIL reset_d g=%0d got=%h exp=%h", g, d_obs[g], PARK);
            end
        end
        // A hit presented while RESET is held must never be answered.
        start_cycle(0, 1'b1, 23'd0, 1'b0, 1'b0, PARK);
        tb_den[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (dtack_w[0] !== 1'b0) begin
                errors++; $display("FAIL reset_hit edge=%0d got=%b exp=0", i, dtack_w[0]);
            end
        end
        as_n[0] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_preload();
        bit ok; int lat; logic [15:0] rd, dv, v; logic dt; int nack;
        for (int g = 0; g < NDUT; g++) begin
            nack = 0;
            for (int off = 0; off < 32; off++) begin
                v = 16'($urandom);
                if (g == 0 && off == 0) v = 16'h4E71;
                if (g == 0 && off == 3) v = 16'hC3A5;
                if (g == 0 && off == 6) v = 16'h6666;
                if (g == 0 && off == 7) v = 16'h7777;
                if (g == 0 && off == 8) v = 16'h1234;
                if (g == 1 && off == 4) v = 16'h0F0F;
                if (g == 1 && off == 5) v = 16'h5A5A;
                do_cycle(g, 1'b0, 23'(off), 1'b0, 1'b0, v, ok, lat, rd, dt, dv);
                model[g][off] = v;
                if (!ok || lat != 1 + ws_tab[g]) nack++;
            end
            checks++;
            if (nack != 0) begin
                errors++; $display("FAIL preload_ack g=%0d bad_cycles=%0d exp=0", g, nack);
            end
        end
    endtask

    task automatic test_read_basic();
        bit ok; int lat; logic [15:0] rd, dv; logic dt;
        do_cycle(0, 1'b1, 23'd0, 1'b0, 1'b0, PARK, ok, lat, rd, dt, dv);
        checks++;
        if (!ok || lat != 2) begin
            errors++; $display("FAIL read_latency acked=%0d got=%0d exp=2", ok, lat);
        end
        checks++;
        if (rd !== 16'h4E71) begin
            errors++; $display("FAIL read_data got=%h exp=4e71", rd);
        end
        checks++;
        if (dt !== 1'b0 || dv !== PARK) begin
            errors++; $display("FAIL read_release dtack=%b d=%h exp dtack=0 d=%h", dt, dv, PARK);
        end
    endtask

    task automatic test_byte_lanes();
        bit ok; int lat; logic [15:0] rd, dv; logic dt;
        do_cycle(0, 1'b0, 23'd8, 1'b0, 1'b1, 16'hABCD, ok, lat, rd, dt, dv);
        do_cycle(0, 1'b1, 23'd8, 1'b1, 1'b1, PARK, ok, lat, rd, dt, dv);
        checks++;
        if (rd !== 16'hAB34) begin
            errors++; $display("FAIL upper_lane got=%h exp=ab34", rd);
        end
        do_cycle(0, 1'b0, 23'd8, 1'b1, 1'b0, 16'h5678, ok, lat, rd, dt, dv);
        do_cycle(0, 1'b1, 23'd8, 1'b0, 1'b1, PARK, ok, lat, rd, dt, dv);
        checks++;
        if (rd !== 16'hAB78) begin
            errors++; $display("FAIL lower_lane got=%h exp=ab78", rd);
        end
        do_cycle(0, 1'b0, 23'd8, 1'b1, 1'b1, 16'h0000, ok, lat, rd, dt, dv);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL nostrobe_ack acked=%0d exp=1", ok);
        end
        do_cycle(0, 1'b1, 23'd8, 1'b0, 1'b0, PARK, ok, lat, rd, dt, dv);
        checks++;
        if (rd !== 16'hAB78) begin
            errors++; $display("FAIL nostrobe_data got=%h exp=ab78", rd);
        end
        model[0][8] = 16'hAB78;
    endtask

    task automatic test_miss();
        int bad_dt = 0;
        int bad_d  = 0;
        start_cycle(0, 1'b1, 23'h800, 1'b0, 1'b0, PARK);
        tb_den[0] = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (dtack_w[0] !== 1'b0) bad_dt++;
            if (d_obs[0] !== PARK) bad_d++;
        end
        checks++;
        if (bad_dt != 0) begin
            errors++; $display("FAIL miss_dtack cycles_high=%0d exp=0", bad_dt);
        end
        checks++;
        if (bad_d != 0) begin
            errors++; $display("FAIL miss_d cycles_driven=%0d exp=0", bad_d);
        end
        as_n[0] = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        bit ok; int lat; logic [15:0] rd, dv; logic dt; int bad;
        start_cycle(1, 1'b0, 23'd4, 1'b0, 1'b0, 16'hFFFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        as_n[1] = 1'b1; uds_n[1] = 1'b1; lds_n[1] = 1'b1; tb_dout[1] = PARK;
        bad = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (dtack_w[1] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL abort_dtack cycles_high=%0d exp=0", bad);
        end
        do_cycle(1, 1'b1, 23'd4, 1'b0, 1'b0, PARK, ok, lat, rd, dt, dv);
        checks++;
        if (rd !== model[1][4]) begin
            errors++; $display("FAIL abort_mem got=%h exp=%h", rd, model[1][4]);
        end
        // RESET while counting down drops the write.
        start_cycle(1, 1'b0, 23'd5, 1'b0, 1'b0, 16'hFFFF);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        as_n[1] = 1'b1; uds_n[1] = 1'b1; lds_n[1] = 1'b1; tb_dout[1] = PARK;
        bad = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (dtack_w[1] !== 1'b0) bad++;
        end
        do_cycle(1, 1'b1, 23'd5, 1'b0, 1'b0, PARK, ok, lat, rd, dt, dv);
        checks++;
        if (bad != 0 || rd !== model[1][5]) begin
            errors++; $display("FAIL wait_reset dtack_cycles=%0d got=%h exp=%h", bad, rd, model[1][5]);
        end
    endtask

    task automatic test_reset_ack();
        bit ok; int lat; logic [15:0] rd, dv; logic dt;
        start_cycle(0, 1'b1, 23'd3, 1'b0, 1'b0, PARK);
        wait_ack(0, 40, ok, lat, rd);
        checks++;
        if (!ok || rd !== model[0][3]) begin
            errors++; $display("FAIL rstack_pre acked=%0d got=%h exp=%h", ok, rd, model[0][3]);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (dtack_w[0] !== 1'b0) begin
            errors++; $display("FAIL rstack_dtack got=%b exp=0", dtack_w[0]);
        end
        rst = 1'b0; as_n[0] = 1'b1; tb_den[0] = 1'b1; tb_dout[0] = PARK;
        #1;
        checks++;
        if (d_obs[0] !== PARK) begin
            errors++; $display("FAIL rstack_d got=%h exp=%h", d_obs[0], PARK);
        end
        @(posedge clk); #1;
        do_cycle(0, 1'b1, 23'd3, 1'b0, 1'b0, PARK, ok, lat, rd, dt, dv);
        checks++;
        if (!ok || lat != 2 || rd !== model[0][3]) begin
            errors++; $display("FAIL rstack_next lat=%0d got=%h exp lat=2 data=%h", lat, rd, model[0][3]);
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int lat; logic [15:0] rd, dv; logic dt;
        for (int w = 1; w <= 2; w++) begin
            do_cycle(2, 1'b1, 23'(w), 1'b0, 1'b0, PARK, ok, lat, rd, dt, dv);
            checks++;
            if (!ok || lat != 1 || rd !== model[2][w]) begin
                errors++; $display("FAIL b2b word=%0d lat=%0d got=%h exp lat=1 data=%h", w, lat, rd, model[2][w]);
            end
        end
    endtask

    task automatic test_as_held();
        bit ok; int lat; logic [15:0] rd, dv; logic dt; int bad = 0;
        start_cycle(0, 1'b1, 23'd6, 1'b0, 1'b0, PARK);
        wait_ack(0, 40, ok, lat, rd);
        addr[0] = 23'd7;
        repeat (5) begin
            @(posedge clk); #1;
            if (dtack_w[0] !== 1'b1 || d_obs[0] !== 16'h6666) bad++;
        end
        end_cycle(0, dt, dv);
        checks++;
        if (!ok || bad != 0) begin
            errors++; $display("FAIL as_held acked=%0d bad_cycles=%0d exp=0", ok, bad);
        end
        checks++;
        if (dt !== 1'b0 || dv !== PARK) begin
            errors++; $display("FAIL as_held_release dtack=%b d=%h exp dtack=0 d=%h", dt, dv, PARK);
        end
    endtask

    task automatic test_random();
        bit ok; int lat; logic [15:0] rd, dv, wd; logic dt, u, l; int g, kind, off, bad;
        logic [23:1] a;
        for (int i = 0; i < 150; i++) begin
            g    = $urandom_range(0, NDUT - 1);
            kind = $urandom_range(0, 9);
            off  = $urandom_range(0, 31);
            u    = 1'($urandom);
            l    = 1'($urandom);
            wd   = 16'($urandom);
            if (kind == 0) begin
                a = 23'($urandom);
                if (a[23:11] == 13'd0) a[23] = 1'b1;
                start_cycle(g, 1'b1, a, u, l, PARK);
                tb_den[g] = 1'b1;
                bad = 0;
                repeat (6) begin
                    @(posedge clk); #1;
                    if (dtack_w[g] !== 1'b0 || d_obs[g] !== PARK) bad++;
                end
                as_n[g] = 1'b1;
                @(posedge clk); #1;
                checks++;
                if (bad != 0) begin
                    errors++; $display("FAIL rnd_miss i=%0d addr=%h bad_cycles=%0d exp=0", i, a, bad);
                end
            end else begin
                do_cycle(g, kind < 5, 23'(off), u, l, wd, ok, lat, rd, dt, dv);
                checks++;
                if (!ok || lat != 1 + ws_tab[g] || dt !== 1'b0 || dv !== PARK) begin
                    errors++; $display("FAIL rnd_timing i=%0d g=%0d lat=%0d exp=%0d dtack_after=%b d_after=%h",
                                       i, g, lat, 1 + ws_tab[g], dt, dv);
                end
                if (kind < 5) begin
                    checks++;
                    if (rd !== model[g][off]) begin
                        errors++; $display("FAIL rnd_read i=%0d g=%0d word=%0d got=%h exp=%h", i, g, off, rd, model[g][off]);
                    end
                end else begin
                    if (!u) model[g][off][15:8] = wd[15:8];
                    if (!l) model[g][off][7:0]  = wd[7:0];
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int g = 0; g < NDUT; g++) begin
            addr[g] = '0; as_n[g] = 1'b1; uds_n[g] = 1'b1; lds_n[g] = 1'b1;
            rw[g] = 1'b1; tb_den[g] = 1'b1; tb_dout[g] = PARK;
        end
        test_reset();
        test_preload();
        test_read_basic();
        test_byte_lanes();
        test_miss();
        test_abort();
        test_reset_ack();
        test_back_to_back();
        test_as_held();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog time=%0t checks=%0d", $time, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
